// File: rtl/imm_extend_pipe_pkg.sv
// Shared types, opcode patterns and the format classifier for the LEGv8 immediate generator.
package imm_pkg;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_B    = 3'd1,
        FMT_CB   = 3'd2,
        FMT_D    = 3'd3,
        FMT_I    = 3'd4,
        FMT_IW   = 3'd5
    } fmt_e;

    localparam int unsigned B_W  = 26;
    localparam int unsigned CB_W = 19;
    localparam int unsigned D_W  = 9;
    localparam int unsigned I_W  = 12;
    localparam int unsigned IW_W = 16;

    localparam logic [5:0]  OP_B     = 6'b000101;
    localparam logic [5:0]  OP_BL    = 6'b100101;
    localparam logic [7:0]  OP_CBZ   = 8'b10110100;
    localparam logic [7:0]  OP_CBNZ  = 8'b10110101;
    localparam logic [7:0]  OP_BCOND = 8'b01010100;
    localparam logic [10:0] OP_LDUR  = 11'b11111000010;
    localparam logic [10:0] OP_STUR  = 11'b11111000000;
    localparam logic [9:0]  OP_ADDI  = 10'b1001000100;
    localparam logic [9:0]  OP_ADDIS = 10'b1011000100;
    localparam logic [9:0]  OP_SUBI  = 10'b1101000100;
    localparam logic [9:0]  OP_SUBIS = 10'b1111000100;
    localparam logic [9:0]  OP_ANDI  = 10'b1001001000;
    localparam logic [9:0]  OP_ORRI  = 10'b1011001000;
    localparam logic [9:0]  OP_EORI  = 10'b1101001000;
    localparam logic [8:0]  OP_MOVZ  = 9'b110100101;
    localparam logic [8:0]  OP_MOVK  = 9'b111100101;

    // Checked in priority order; the first matching format wins.
    function automatic fmt_e classify(input logic [31:0] instr);
        fmt_e f;
        f = FMT_NONE;
        if (instr[31:26] == OP_B || instr[31:26] == OP_BL) begin
            f = FMT_B;
        end else if (instr[31:24] == OP_CBZ || instr[31:24] == OP_CBNZ ||
                     instr[31:24] == OP_BCOND) begin
            f = FMT_CB;
        end else if (instr[31:21] == OP_LDUR || instr[31:21] == OP_STUR) begin
            f = FMT_D;
        end else if (instr[31:22] == OP_ADDI  || instr[31:22] == OP_ADDIS ||
                     instr[31:22] == OP_SUBI  || instr[31:22] == OP_SUBIS ||
                     instr[31:22] == OP_ANDI  || instr[31:22] == OP_ORRI  ||
                     instr[31:22] == OP_EORI) begin
            f = FMT_I;
        end else if (instr[31:23] == OP_MOVZ || instr[31:23] == OP_MOVK) begin
            f = FMT_IW;
        end
        return f;
    endfunction

endpackage

// File: rtl/imm_extend_pipe_core.sv
// Combinational immediate extraction and extension for a pre-classified instruction.
module imm_extend_core
    import imm_pkg::*;
#(
    parameter int unsigned XLEN         = 64,
    parameter bit          SHIFT_BRANCH = 1'b0
) (
    input  fmt_e             fmt_i,
    input  logic [25:0]      field_i,
    output logic [XLEN-1:0]  imm_o,
    output logic             illegal_o
);

    logic [B_W-1:0]  b_fld;
    logic [CB_W-1:0] cb_fld;
    logic [D_W-1:0]  d_fld;
    logic [I_W-1:0]  i_fld;
    logic [IW_W-1:0] iw_fld;
    logic [1:0]      hw;
    logic [63:0]     wide;

    assign b_fld  = field_i[25:0];
    assign cb_fld = field_i[23:5];
    assign d_fld  = field_i[20:12];
    assign i_fld  = field_i[21:10];
    assign iw_fld = field_i[20:5];
    assign hw     = field_i[22:21];

    // Work at 64 bits and truncate so sign extension and shifts behave the same for both XLENs.
    always_comb begin
        wide      = '0;
        illegal_o = 1'b0;
        case (fmt_i)
            FMT_B: begin
                wide = {{(64-B_W){b_fld[B_W-1]}}, b_fld};
                if (SHIFT_BRANCH) wide = wide << 2;
            end
            FMT_CB: begin
                wide = {{(64-CB_W){cb_fld[CB_W-1]}}, cb_fld};
                if (SHIFT_BRANCH) wide = wide << 2;
            end
            FMT_D:   wide = {{(64-D_W){d_fld[D_W-1]}}, d_fld};
            FMT_I:   wide = {{(64-I_W){1'b0}}, i_fld};
            FMT_IW: begin
                if (XLEN == 32 && hw[1]) begin
                    illegal_o = 1'b1;
                end else begin
                    wide = {{(64-IW_W){1'b0}}, iw_fld} << {hw, 4'b0000};
                end
            end
            default: illegal_o = 1'b1;
        endcase
    end

    assign imm_o = wide[XLEN-1:0];

endmodule

// File: rtl/imm_extend_pipe.sv
// Two-stage valid/ready immediate generator: classify, then extend, with flush and illegal counter.
module imm_extend_pipe
    import imm_pkg::*;
#(
    parameter int unsigned XLEN         = 64,
    parameter bit          SHIFT_BRANCH = 1'b0,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("imm_extend_pipe: XLEN must be 32 or 64");
    end

    logic             s1_valid_q, s1_valid_d;
    fmt_e             s1_fmt_q, s1_fmt_d;
    logic [25:0]      s1_field_q, s1_field_d;
    logic             s2_valid_q, s2_valid_d;
    fmt_e             s2_fmt_q, s2_fmt_d;
    logic [XLEN-1:0]  s2_imm_q, s2_imm_d;
    logic             s2_illegal_q, s2_illegal_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             s2_load;
    logic             accept;
    logic             out_fire;
    logic [XLEN-1:0]  core_imm;
    logic             core_illegal;

    assign s2_load  = s1_valid_q & (~s2_valid_q | out_ready);
    assign in_ready = ~s1_valid_q | s2_load;
    assign accept   = in_valid & in_ready & ~flush;
    assign out_fire = s2_valid_q & out_ready;

    imm_extend_core #(
        .XLEN         (XLEN),
        .SHIFT_BRANCH (SHIFT_BRANCH)
    ) u_core (
        .fmt_i     (s1_fmt_q),
        .field_i   (s1_field_q),
        .imm_o     (core_imm),
        .illegal_o (core_illegal)
    );

    always_comb begin
        s1_valid_d   = s1_valid_q;
        s1_fmt_d     = s1_fmt_q;
        s1_field_d   = s1_field_q;
        s2_valid_d   = s2_valid_q;
        s2_fmt_d     = s2_fmt_q;
        s2_imm_d     = s2_imm_q;
        s2_illegal_d = s2_illegal_q;
        cnt_d        = cnt_q;

        if (flush) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
        end else begin
            if (accept)       s1_valid_d = 1'b1;
            else if (s2_load) s1_valid_d = 1'b0;
            if (s2_load)       s2_valid_d = 1'b1;
            else if (out_fire) s2_valid_d = 1'b0;
        end

        if (accept) begin
            s1_fmt_d   = classify(in_instr);
            s1_field_d = in_instr[25:0];
        end

        // Output registers keep their last value across a flush.
        if (s2_load && !flush) begin
            s2_fmt_d     = s1_fmt_q;
            s2_imm_d     = core_imm;
            s2_illegal_d = core_illegal;
        end

        if (out_fire && s2_illegal_q && cnt_q != '1) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q   <= 1'b0;
            s1_fmt_q     <= FMT_NONE;
            s1_field_q   <= '0;
            s2_valid_q   <= 1'b0;
            s2_fmt_q     <= FMT_NONE;
            s2_imm_q     <= '0;
            s2_illegal_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_fmt_q     <= s1_fmt_d;
            s1_field_q   <= s1_field_d;
            s2_valid_q   <= s2_valid_d;
            s2_fmt_q     <= s2_fmt_d;
            s2_imm_q     <= s2_imm_d;
            s2_illegal_q <= s2_illegal_d;
            cnt_q        <= cnt_d;
        end
    end

    assign out_valid   = s2_valid_q;
    assign out_imm     = s2_imm_q;
    assign out_fmt     = s2_fmt_q;
    assign out_illegal = s2_illegal_q;
    assign illegal_cnt = cnt_q;

endmodule

// File: doc/imm_extend_pipe.md
Name: imm_extend_pipe

Overview:
- Parametrised, pipelined immediate generator for the LEGv8/ARMv8 datapath; successor to the combinational sign-extend unit.
- Classifies a 32-bit instruction into B, CB, D, I or IW format, then extracts and sign- or zero-extends the immediate to XLEN.
- Optionally pre-scales branch offsets by 4. Adds a 2-stage valid/ready pipeline, flush, and an illegal-instruction counter.
- Sits between instruction fetch/decode and the register-read/ALU-operand mux.

Parameters:
- XLEN, 64, output immediate width; legal values 32 or 64 (elaboration error otherwise).
- SHIFT_BRANCH, 0, when 1 the B and CB immediates are shifted left by 2 after extension.
- CNT_W, 16, width of the saturating illegal-instruction counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  synchronous pipeline clear.
- in_valid  in  1  instruction present.
- in_ready  out  1  block can accept this cycle.
- in_instr  in  32  instruction word.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts.
- out_imm  out  XLEN  extended immediate.
- out_fmt  out  3  format code: 0 NONE, 1 B, 2 CB, 3 D, 4 I, 5 IW.
- out_illegal  out  1  instruction carries no legal immediate.
- illegal_cnt  out  CNT_W  saturating count of illegal results consumed.

Behaviour:
- Reset, clk edge with reset=1: both stage valids=0, out_imm=0, out_fmt=0, out_illegal=0, illegal_cnt=0. Reset mid-operation discards in-flight data. in_ready is 1 in the first cycle after reset.
- Stage 1 (classify) registers instr and fmt. Decode priority:
  - B: [31:26] = 000101 or 100101.
  - CB: [31:24] = 10110100, 10110101 or 01010100.
  - D: [31:21] = 11111000010 or 11111000000.
  - I: [31:22] in {1001000100, 1011000100, 1101000100, 1111000100, 1001001000, 1011001000, 1101001000}.
  - IW: [31:23] = 110100101 or 111100101.
  - Anything else: NONE.
- Stage 2 (extend) registers imm/fmt/illegal:
  - B: sext(instr[25:0]).
  - CB: sext(instr[23:5]), 19 bits.
  - D: sext(instr[20:12]), 9 bits.
  - I: zext(instr[21:10]), 12 bits.
  - IW: zext(instr[20:5]) << (16*instr[22:21]).
  - SHIFT_BRANCH=1: B/CB result <<2, truncated to XLEN.
  - NONE: imm=0, illegal=1.
  - XLEN=32 with IW hw>=2: imm=0, illegal=1, fmt stays IW.
- Handshake:
  - s2_load = s1_valid & (!s2_valid | out_ready).
  - in_ready = !s1_valid | s2_load.
  - Input accepted when in_valid & in_ready & !flush.
  - Latency: 2 cycles accept-to-out_valid. Throughput: 1 per cycle with out_ready held high.
- Stall: out_valid=1 and out_ready=0 holds out_imm/fmt/illegal stable. Stage 1 fills, then in_ready=0. No data is lost or duplicated.
- Flush: clears s1_valid and s2_valid at the edge. The input offered in the flush cycle is not accepted. illegal_cnt is unaffected. A flush coinciding with an output handshake still counts that result.
- illegal_cnt increments on out_valid & out_ready & out_illegal. It saturates at 2^CNT_W-1 and clears only on reset.
- out_imm/fmt/illegal hold their last value when out_valid=0.

Decomposition:
- Package imm_pkg holds:
  - fmt enum (NONE..IW, 3 bits).
  - Opcode constants for every pattern above.
  - A classify function (instr → fmt).
  - Field widths 26/19/9/12/16.
- One sub-module, imm_extend_core: combinational fmt+instr → imm/illegal, parametrised on XLEN and SHIFT_BRANCH. The pipe wrapper owns the registers, handshake and counter.

Test Plan:
- XLEN=64, SHIFT_BRANCH=0, in_instr=0x17FFFFFF (B, imm26 all ones), out_ready=1 → 2 cycles later out_imm=0xFFFFFFFFFFFFFFFF, fmt=1, illegal=0.
- CBZ 0xB4000041 (imm19=2) with SHIFT_BRANCH=1 → out_imm=8, fmt=2. LDUR 0xF85F8000 (imm9=0x1F8) → out_imm=0xFFFFFFFFFFFFFFF8, fmt=3.
- MOVZ 0xD2A24680 (hw=1, imm16=0x1234) → out_imm=0x12340000, fmt=5. With XLEN=32 and hw=3 (0xD2E24680) → imm=0, illegal=1.
- Stream 4 instructions back-to-back, out_ready=0 for cycles 3-6 → in_ready drops once both stages are full. Outputs appear in order, none lost or duplicated, and stay stable while stalled.
- 3 illegal words (0x00000000) consumed, then flush with one in flight → illegal_cnt=3, out_valid=0 next cycle. With CNT_W=2, 5 illegals → count saturates at 3.
- Assert reset while both stages are valid → next cycle out_valid=0, all outputs 0, in_ready=1.
